// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: gain constant, angle-table helper, pi constant,
// fixed-point multiply helper and the iterative FSM state type.
package cordic_pkg;

    localparam real CORDIC_LAMBDA = 0.6072529350;
    localparam real CORDIC_PI_R   = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} cordic_state_t;

    // atan(2^-i) / pi scaled by 2^w, rounded to nearest (always non-negative)
    function automatic longint cordic_atan(input int i, input int w);
        real th;
        th = $atan(2.0 ** (-i)) / CORDIC_PI_R * (2.0 ** w);
        return longint'($rtoi(th + 0.5));
    endfunction

    // +pi in an angle format where 1.0 (== pi) is 2^w
    function automatic longint cordic_pi(input int w);
        return longint'(1) << w;
    endfunction

    // Inverse CORDIC gain as a Q1.w constant
    function automatic longint cordic_lambda(input int w);
        return longint'($rtoi(CORDIC_LAMBDA * (2.0 ** w) + 0.5));
    endfunction

    // Signed fixed-point multiply followed by an arithmetic right shift
    function automatic longint fx_mul(input longint a, input longint b, input int sh);
        return (a * b) >>> sh;
    endfunction

endpackage

// File: rtl/cordic_vector_if.sv
// Sample-in / result-out handshake bundle of the vectoring CORDIC.
interface cordic_vector_if #(
    parameter int DW = 10,
    parameter int AW = DW
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xin;
    logic signed [DW-1:0] yin;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW:0]   mag;
    logic signed [AW-1:0] ang;

    modport master (
        output in_valid, xin, yin, out_ready,
        input  in_ready, out_valid, mag, ang
    );

    modport slave (
        input  in_valid, xin, yin, out_ready,
        output in_ready, out_valid, mag, ang
    );
endinterface

// File: rtl/cordic_vec_rotator.sv
// One vectoring micro-rotation: drives y towards zero, accumulating the angle.
module cordic_vec_rotator #(
    parameter int DW = 10,
    parameter int AW = DW,
    parameter int IW = 4
) (
    input  logic signed [DW+1:0] x,
    input  logic signed [DW+1:0] y,
    input  logic signed [AW+1:0] a,
    input  logic signed [AW+1:0] th,
    input  logic        [IW-1:0] i,
    output logic signed [DW+1:0] x_nxt,
    output logic signed [DW+1:0] y_nxt,
    output logic signed [AW+1:0] a_nxt
);
    logic signed [DW+1:0] xs;
    logic signed [DW+1:0] ys;

    // Rotate clockwise when y >= 0, counter-clockwise otherwise; all terms use old values
    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        if (!y[DW+1]) begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            a_nxt = a + th;
        end else begin
            x_nxt = x - ys;
            y_nxt = y + xs;
            a_nxt = a - th;
        end
    end
endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> (magnitude, phase), one
// micro-rotation per cycle through a shared rotator.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int DW   = 10,
    parameter int AW   = DW,
    parameter int ITER = DW
) (
    input logic            clk,
    input logic            rst_n,
    cordic_vector_if.slave bus
);
    localparam int     IW     = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int     TN     = 1 << IW;
    localparam longint LAMBDA = cordic_lambda(DW);
    localparam logic signed [AW+1:0] PI_A = (AW+2)'(cordic_pi(AW));

    cordic_state_t        state;
    logic signed [DW+1:0] x_q, y_q, x_nxt, y_nxt;
    logic signed [AW+1:0] a_q, a_nxt;
    logic        [IW-1:0] i_q;
    logic                 zero_flag;
    logic                 out_valid_q;
    logic signed [DW:0]   mag_q;
    logic signed [AW-1:0] ang_q;
    logic signed [DW+1:0] xin_w, yin_w;
    logic signed [AW+1:0] th_tab [TN];
    logic signed [AW+1:0] th;

    // Q1.(DW-1) inputs sign-extended into the Q3.(DW-1) working format
    assign xin_w = (DW+2)'(bus.xin);
    assign yin_w = (DW+2)'(bus.yin);

    // Angle table in Q2.AW; unused slots past ITER-1 are zero
    for (genvar k = 0; k < TN; k++) begin : g_atan
        localparam logic signed [AW+1:0] TH = (k < ITER) ? (AW+2)'(cordic_atan(k, AW)) : '0;
        assign th_tab[k] = TH;
    end
    assign th = th_tab[i_q];

    cordic_vec_rotator #(
        .DW (DW),
        .AW (AW),
        .IW (IW)
    ) u_rot (
        .x     (x_q),
        .y     (y_q),
        .a     (a_q),
        .th    (th),
        .i     (i_q),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .a_nxt (a_nxt)
    );

    // Remove the CORDIC gain: (x * lambda) >>> DW, truncated to DW+1 bits
    function automatic logic signed [DW:0] scale_mag(input logic signed [DW+1:0] xv);
        longint p;
        p = fx_mul(longint'(xv), LAMBDA, DW);
        return (DW+1)'(p);
    endfunction

    // Control FSM and datapath registers: load/pre-rotate, iterate, scale, hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            a_q         <= '0;
            i_q         <= '0;
            zero_flag   <= 1'b0;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            ang_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Left half-plane: negate the vector and start from +/-pi
                        if (!bus.xin[DW-1]) begin
                            x_q <= xin_w;
                            y_q <= yin_w;
                            a_q <= '0;
                        end else begin
                            x_q <= -xin_w;
                            y_q <= -yin_w;
                            a_q <= bus.yin[DW-1] ? -PI_A : PI_A;
                        end
                        zero_flag <= (bus.xin == '0) && (bus.yin == '0);
                        i_q       <= '0;
                        state     <= ROT;
                    end
                end
                ROT: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    a_q <= a_nxt;
                    i_q <= i_q + 1'b1;
                    if (i_q == IW'(ITER - 1)) begin
                        state <= SCALE;
                    end
                end
                SCALE: begin
                    // Dropping the guard bit and the top bit wraps exactly +pi to -pi
                    if (zero_flag) begin
                        mag_q <= '0;
                        ang_q <= '0;
                    end else begin
                        mag_q <= scale_mag(x_q);
                        ang_q <= a_q[AW:1];
                    end
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.mag       = mag_q;
    assign bus.ang       = ang_q;

endmodule

// File: doc/cordic_vector.md
# cordic_vector

Iterative vectoring-mode CORDIC that converts a Cartesian vector (x, y) into magnitude and phase, atan2-style. It is the inverse of the team's pipelined rotation-mode CORDIC: same fixed-point formats, same angle encoding ([-1.0, 1.0) ↔ [-π, π)), same gain constant. It serves phase detectors and polar-conversion paths. It runs one micro-rotation per cycle through a single shared datapath, with valid/ready handshakes on both sides.

## Interface
- `DW`, default 10: data width; `xin`/`yin` are Q1.(DW-1).
- `AW`, default DW: angle width; `ang` is Q1.(AW-1), [-1.0, 1.0) ↔ [-π, π).
- `ITER`, default DW: number of micro-rotations, legal range 1..DW+1.
- `clk` in, 1: the single clock; all state updates on the rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `in_valid` in, 1: an input sample is offered.
- `in_ready` out, 1: high only in IDLE.
- `xin` in, DW: signed x, Q1.(DW-1).
- `yin` in, DW: signed y, Q1.(DW-1).
- `out_valid` out, 1: result held stable until accepted.
- `out_ready` in, 1: the consumer accepts the result.
- `mag` out, DW+1: signed magnitude, Q2.(DW-1), always ≥ 0.
- `ang` out, AW: signed phase, Q1.(AW-1).

## Operation
Internal widths:
- x and y registers are DW+2 bits, Q3.(DW-1), which absorbs the negation of -1.0, the √2 growth and the 1.647 CORDIC gain.
- The angle accumulator is AW+2 bits, Q2.AW: one guard fraction bit, plus an integer bit so that ±π is representable.

FSM states are IDLE, ROT, SCALE and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`, load and pre-rotate: if xin ≥ 0, x = xin, y = yin, a = 0. Otherwise x = -xin, y = -yin, and a = +π if yin ≥ 0, else -π.
  - Set `zero_flag` = (xin == 0 && yin == 0).
  - Clear the iteration count `i`, go to ROT.
- ROT (stage `i`, with θi = atan(2^-i)/π · 2^AW):
  - If y ≥ 0: x += y>>>i, y -= x>>>i, a += θi.
  - Otherwise: x -= y>>>i, y += x>>>i, a -= θi.
  - All three updates use the old values; shifts are arithmetic.
  - `i` increments each cycle. After stage ITER-1, go to SCALE.
- SCALE:
  - mag = (x · λ) >>> DW, with λ = round(0.6072529350 · 2^DW) held as a Q1.DW constant. The product is truncated to DW+1 bits.
  - ang = (a >>> 1) truncated to AW bits. A result of exactly +π therefore wraps to -1.0 (-π). This is intended.
  - If `zero_flag` is set, force mag = 0 and ang = 0.
  - Set `out_valid`, go to DONE.
- DONE:
  - Hold `mag`, `ang` and `out_valid`.
  - On `out_ready`, clear `out_valid` and go to IDLE.
  - `in_ready` stays 0 in this state, so there is no same-cycle turnaround.

Boundaries:
- xin = -1.0 and yin = -1.0 are legal; the negation fits in the widened registers.
- The maximum magnitude is √2 · 2^(DW-1), which fits in DW+1 bits.
- `in_valid` arriving outside IDLE is ignored; the source must hold it until `in_ready`.
- `out_ready` asserted outside DONE has no effect.

## Timing
- Reset values: state = IDLE, `out_valid` = 0, `mag` = 0, `ang` = 0, `in_ready` = 1, internal x/y/a/i = 0, `zero_flag` = 0.
- Accept edge T: both `in_valid` and `in_ready` are high.
- ROT occupies edges T+1 .. T+ITER. SCALE runs at edge T+ITER+1.
- `out_valid` is high from cycle T+ITER+1 onward.
- Minimum spacing between accepts is ITER+3 cycles.
- Reset asserted mid-operation: the transaction is aborted immediately. Outputs go to their reset values, and no result is ever presented.
- `in_ready` is decoded combinationally from state only; it has no path from `in_valid`.

## Structure
- Package `cordic_pkg`, shared with the rotation-mode CORDIC:
  - `CORDIC_LAMBDA` (real)
  - function `cordic_atan(i, w)` returning θi as a w-bit constant
  - the π constant for a given width
  - the FSM `typedef enum` {IDLE, ROT, SCALE, DONE}
- The fixed-point multiply uses the existing Fixedpoint package helper.
- One sub-module, `cordic_vec_rotator`: a combinational micro-rotation with a variable shift.
  - Inputs: x, y, a, θ, `i`.
  - Outputs: next x, y, a; direction chosen by the sign of y.
  - The angle constant is indexed from a localparam array built with `cordic_atan` in a generate loop.

## Test plan
All values use DW = AW = ITER = 10, so 1.0 = 512. Tolerance is ±3 LSB on `mag` and ±2 LSB on `ang` unless stated otherwise.
- (256, 0) → `mag` ≈ 256, `ang` ≈ 0. `out_valid` rises exactly 11 cycles after the accept edge.
- (0, 256) → `mag` ≈ 256, `ang` ≈ 256 (π/2). Also (0, -256) → `ang` ≈ -256.
- (-256, 0) → `mag` ≈ 256, `ang` ∈ {-512, 511}, covering the +π wrap.
- (-512, -512) → `mag` ≈ 724, `ang` ≈ -384 (-3π/4), with no overflow. Also (0, 0) → `mag` = 0, `ang` = 0 exactly.
- Backpressure: hold `out_ready` low for 5 cycles after `out_valid`. `mag`, `ang` and `out_valid` must stay stable, and `in_ready` must stay 0 while `in_valid` is held high. On release, the next sample is accepted one cycle after leaving DONE.
- Reset mid-ROT: drop `rst_n` at accept+4. `out_valid` must be 0 immediately, `mag`/`ang` = 0, and `in_ready` = 1 after release. The next transaction must produce correct results.
